// File: rtl/if_stage_pkg.sv
// Shared constants, state encodings and PC-update opcodes for the fetch stage.
// Build option: define IF_DELAY_SLOT_EN to deliver the word after a taken branch.
package if_stage_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] IF_PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INST    = 32'h0000_0000;

`ifdef IF_DELAY_SLOT_EN
    localparam bit IF_DELAY_SLOT = 1'b1;
`else
    localparam bit IF_DELAY_SLOT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    typedef enum logic [1:0] {
        PC_HOLD        = 2'd0,
        PC_ADVANCE     = 2'd1,
        PC_REDIRECT    = 2'd2,
        PC_SET_PENDING = 2'd3
    } pc_op_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// Fetch PC register: sequential step, immediate redirect, or a redirect parked
// until the fetch currently on the bus completes.
module if_stage_pc_gen
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] PC_STEP  = IF_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_op_e      pc_op_i,
    input  logic [31:0] target_i,
    output logic [31:0] fetch_pc_o
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_q, pend_d;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pend_d     = pend_q;
        case (pc_op_i)
            // A parked target takes priority over the sequential step.
            PC_ADVANCE: begin
                fetch_pc_d = pend_q ? pend_pc_q : fetch_pc_q + PC_STEP;
                pend_d     = 1'b0;
            end
            PC_REDIRECT: begin
                fetch_pc_d = align_word(target_i);
                pend_d     = 1'b0;
            end
            PC_SET_PENDING: begin
                pend_pc_d = align_word(target_i);
                pend_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= 32'h0;
            pend_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_q     <= pend_d;
        end
    end

    assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: req/ack fetch FSM, skid register and output register into ID.
// Build option: IF_DELAY_SLOT_EN (see if_stage_pkg).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] PC_STEP  = IF_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branchEnable_i,
    input  logic [31:0] branchAddr_i,
    output logic        imemReq_o,
    output logic [31:0] imemAddr_o,
    input  logic        imemAck_i,
    input  logic [31:0] imemData_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    // state   | meaning
    // IF_IDLE | reset, first request issued on the next edge
    // IF_REQ  | request on the bus (or one-cycle bubble after an ack)
    // IF_HOLD | acked word parked in skid, ID stalled, bus idle
    if_state_e   state_q, state_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] skid_q, skid_d;
    logic        discard_q, discard_d;
    pc_op_e      pc_op;
    logic [31:0] fetch_pc;
    logic        ack, redir, drop, slot_free;

    if_stage_pc_gen #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk        (clk),
        .rst        (rst),
        .pc_op_i    (pc_op),
        .target_i   (branchAddr_i),
        .fetch_pc_o (fetch_pc)
    );

    assign ack       = req_q & imemAck_i;
    assign redir     = branchEnable_i & ~stall_i;
    assign drop      = redir & ~IF_DELAY_SLOT;
    assign slot_free = ~valid_q | ~stall_i;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        skid_d    = skid_q;
        discard_d = discard_q;
        pc_op     = PC_HOLD;
        if (!stall_i) begin
            valid_d = 1'b0;
        end
        case (state_q)
            IF_IDLE: begin
                state_d = IF_REQ;
                req_d   = 1'b1;
            end
            IF_REQ: begin
                req_d = ~ack;
                if (ack && discard_q) begin
                    discard_d = 1'b0;
                    pc_op     = PC_ADVANCE;
                end else if (ack && slot_free) begin
                    pc_op = PC_ADVANCE;
                    if (!drop) begin
                        valid_d = 1'b1;
                        pc_d    = fetch_pc;
                        inst_d  = imemData_i;
                    end
                end else if (ack) begin
                    skid_d  = imemData_i;
                    state_d = IF_HOLD;
                end
                // An outstanding request keeps its address; the target waits for its ack.
                if (redir) begin
                    if (ack) begin
                        pc_op = PC_REDIRECT;
                    end else if (req_q || IF_DELAY_SLOT) begin
                        pc_op     = PC_SET_PENDING;
                        discard_d = ~IF_DELAY_SLOT;
                    end else begin
                        pc_op = PC_REDIRECT;
                    end
                end
            end
            IF_HOLD: begin
                if (!stall_i) begin
                    state_d = IF_REQ;
                    req_d   = 1'b1;
                    pc_op   = redir ? PC_REDIRECT : PC_ADVANCE;
                    if (!drop) begin
                        valid_d = 1'b1;
                        pc_d    = fetch_pc;
                        inst_d  = skid_q;
                    end
                end
            end
            default: begin
                state_d = IF_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IF_IDLE;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            pc_q      <= 32'h0;
            inst_q    <= NOP_INST;
            skid_q    <= NOP_INST;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            skid_q    <= skid_d;
            discard_q <= discard_d;
        end
    end

    assign imemReq_o  = req_q;
    assign imemAddr_o = fetch_pc;
    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign valid_o    = valid_q;

endmodule
